// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// GameSequencer
//
// Purpose:
//   Top-level flow controller for the counting game. A single FSM walks the
//   player through prelim -> game -> answer -> post periods, counts the user's
//   up/down presses, compares the final count against the number of magic
//   symbols the generator showed, and then advances the level, costs a life,
//   declares a win or ends the game. Period lengths, pass tolerance, number of
//   lives and number of levels are all parameters.
//
// Ports:
//   Clk100M     in   1        system clock
//   reset       in   1        asynchronous, active-high reset
//   tick1Hz     in   1        one-cycle pulse per second
//   start       in   1        one-cycle pulse, begin/restart a game
//   userUp      in   1        one-cycle press blip, count up
//   userDown    in   1        one-cycle press blip, count down
//   magicCount  in   COUNT_W  magic-symbol count reported by the generator
//   phase       out  4        one-hot {post,answer,game,pre}, 0 outside periods
//   secsLeft    out  8        seconds remaining in the current period
//   startGen    out  1        one-cycle pulse on the first GAME cycle
//   stopGen     out  1        one-cycle pulse on the first ANSWER cycle
//   userCount   out  COUNT_W  user's running count
//   curLevel    out  LEVEL_W  current level, 0-based
//   livesLeft   out  4        remaining lives
//   symGenMax   out  32       symbol generator period for the current level
//   win         out  1        high while in the WIN state
//   gameOver    out  1        high while in the OVER state
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter int          NUM_LEVELS  = 10,
  parameter int          LEVEL_W     = 4,
  parameter int          COUNT_W     = 8,
  parameter int          PRE_SECS    = 3,
  parameter int          GAME_SECS   = 10,
  parameter int          ANSWER_SECS = 5,
  parameter int          POST_SECS   = 3,
  parameter int          LIVES       = 3,
  parameter int          TOLERANCE   = 0,
  parameter logic [31:0] BASE_MAX    = 32'd100000000,
  parameter logic [31:0] MAX_STEP    = 32'd10000000,
  parameter logic [31:0] MIN_MAX     = 32'd20000000
) (
  input  logic               Clk100M,
  input  logic               reset,
  input  logic               tick1Hz,
  input  logic               start,
  input  logic               userUp,
  input  logic               userDown,
  input  logic [COUNT_W-1:0] magicCount,
  output logic [3:0]         phase,
  output logic [7:0]         secsLeft,
  output logic               startGen,
  output logic               stopGen,
  output logic [COUNT_W-1:0] userCount,
  output logic [LEVEL_W-1:0] curLevel,
  output logic [3:0]         livesLeft,
  output logic [31:0]        symGenMax,
  output logic               win,
  output logic               gameOver
);

  // FSM encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PRE    = 3'd1;
  localparam logic [2:0] GAME   = 3'd2;
  localparam logic [2:0] ANSWER = 3'd3;
  localparam logic [2:0] POST   = 3'd4;
  localparam logic [2:0] JUDGE  = 3'd5;
  localparam logic [2:0] WIN    = 3'd6;
  localparam logic [2:0] OVER   = 3'd7;

  localparam logic [7:0]         PRE_LOAD    = 8'(PRE_SECS);
  localparam logic [7:0]         GAME_LOAD   = 8'(GAME_SECS);
  localparam logic [7:0]         ANSWER_LOAD = 8'(ANSWER_SECS);
  localparam logic [7:0]         POST_LOAD   = 8'(POST_SECS);
  localparam logic [3:0]         LIVES_LOAD  = 4'(LIVES);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX   = {COUNT_W{1'b1}};
  localparam logic [COUNT_W:0]   TOL_VALUE   = (COUNT_W + 1)'(TOLERANCE);

  // Below this value one more step would cross the floor; computed one bit
  // wider so that a large MIN_MAX + MAX_STEP cannot wrap.
  localparam logic [32:0] FLOOR_LIMIT = {1'b0, MIN_MAX} + {1'b0, MAX_STEP};

  logic [2:0]         state;
  logic [2:0]         nextState;
  logic               entryCycle;
  logic               periodTick;
  logic               periodDone;
  logic               timedState;
  logic               passed;
  logic               lastLevel;
  logic               leaveAnswer;
  logic               enterGame;
  logic [COUNT_W-1:0] countNext;
  logic [COUNT_W-1:0] magicLatched;
  logic [COUNT_W:0]   diff;
  logic [COUNT_W:0]   diffNext;
  logic [31:0]        steppedMax;

  // Seconds to load into secsLeft when entering a given state. Untimed states
  // load 0 so secsLeft reads 0 outside the four periods.
  function automatic logic [7:0] loadSecs(input logic [2:0] s);
    case (s)
      PRE:     loadSecs = PRE_LOAD;
      GAME:    loadSecs = GAME_LOAD;
      ANSWER:  loadSecs = ANSWER_LOAD;
      POST:    loadSecs = POST_LOAD;
      default: loadSecs = 8'd0;
    endcase
  endfunction

  // Phase indicator is a pure decode of the state, so reset clears it at once.
  always_comb begin
    phase = 4'b0000;
    case (state)
      PRE:     phase = 4'b0001;
      GAME:    phase = 4'b0010;
      ANSWER:  phase = 4'b0100;
      POST:    phase = 4'b1000;
      default: phase = 4'b0000;
    endcase
  end

  assign timedState = (phase != 4'b0000);
  assign win        = (state == WIN);
  assign gameOver   = (state == OVER);

  // A tick landing in the first cycle of a period is dropped so that every
  // period lasts a full *_SECS ticks counted from after entry. The tick that
  // arrives while secsLeft is 1 ends the period instead of showing 0.
  assign periodTick = tick1Hz && !entryCycle && timedState;
  assign periodDone = periodTick && (secsLeft == 8'd1);

  assign passed    = (diff <= TOL_VALUE);
  assign lastLevel = (curLevel == LAST_LEVEL);

  // Next-state logic. start is honoured only from the resting states.
  always_comb begin
    nextState = state;
    case (state)
      IDLE, WIN, OVER: if (start) nextState = PRE;
      PRE:             if (periodDone) nextState = GAME;
      GAME:            if (periodDone) nextState = ANSWER;
      ANSWER:          if (periodDone) nextState = POST;
      POST:            if (periodDone) nextState = JUDGE;
      JUDGE: begin
        if (passed)
          nextState = lastLevel ? WIN : PRE;
        else
          nextState = (livesLeft <= 4'd1) ? OVER : PRE;
      end
      default:         nextState = IDLE;
    endcase
  end

  assign enterGame   = (state == PRE) && (nextState == GAME);
  assign leaveAnswer = (state == ANSWER) && (nextState == POST);

  // Saturating user counter. Simultaneous up and down cancel out. Presses are
  // only accepted during GAME and ANSWER; the count is cleared on GAME entry
  // and otherwise stays visible for the player to read.
  always_comb begin
    countNext = userCount;
    if (enterGame) begin
      countNext = '0;
    end else if ((state == GAME) || (state == ANSWER)) begin
      if (userUp && !userDown && (userCount != COUNT_MAX))
        countNext = userCount + COUNT_W'(1);
      else if (userDown && !userUp && (userCount != '0))
        countNext = userCount - COUNT_W'(1);
    end
  end

  // Absolute error, one bit wider than the counts. Uses the count as it will
  // be after this cycle so a press in the final ANSWER cycle is not lost.
  always_comb begin
    if (countNext >= magicLatched)
      diffNext = {1'b0, countNext} - {1'b0, magicLatched};
    else
      diffNext = {1'b0, magicLatched} - {1'b0, countNext};
  end

  // Next generator period: step down but clamp at the floor, comparing first
  // so the subtraction can never wrap.
  assign steppedMax = ({1'b0, symGenMax} >= FLOOR_LIMIT) ? (symGenMax - MAX_STEP) : MIN_MAX;

  // State register, period countdown and the generator start/stop pulses.
  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      entryCycle <= 1'b0;
      secsLeft   <= 8'd0;
      startGen   <= 1'b0;
      stopGen    <= 1'b0;
    end else begin
      state      <= nextState;
      entryCycle <= (nextState != state);
      startGen   <= enterGame;
      stopGen    <= (state == GAME) && (nextState == ANSWER);
      if (nextState != state)
        secsLeft <= loadSecs(nextState);
      else if (periodTick)
        secsLeft <= secsLeft - 8'd1;
    end
  end

  // User count register.
  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset)
      userCount <= '0;
    else
      userCount <= countNext;
  end

  // The generator's count is captured while stopGen is high, i.e. in the
  // first ANSWER cycle once the generator has been told to stop. The error is
  // registered as ANSWER closes and judged after POST.
  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      magicLatched <= '0;
      diff         <= '0;
    end else begin
      if (stopGen)
        magicLatched <= magicCount;
      if (leaveAnswer)
        diff <= diffNext;
    end
  end

  // Level, lives and generator speed. Restarting from WIN/OVER rewinds the
  // campaign; JUDGE applies the outcome of the round just played. Winning the
  // last level leaves level and speed where they were.
  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      curLevel  <= '0;
      livesLeft <= LIVES_LOAD;
      symGenMax <= BASE_MAX;
    end else if (((state == WIN) || (state == OVER)) && start) begin
      curLevel  <= '0;
      livesLeft <= LIVES_LOAD;
      symGenMax <= BASE_MAX;
    end else if (state == JUDGE) begin
      if (passed) begin
        if (!lastLevel) begin
          curLevel  <= curLevel + LEVEL_W'(1);
          symGenMax <= steppedMax;
        end
      end else if (livesLeft <= 4'd1) begin
        livesLeft <= 4'd0;
      end else begin
        livesLeft <= livesLeft - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//
// Purpose:
//   Self-checking bench for game_sequencer. Whole rounds are played with
//   random press counts and magic counts; a round-level reference model
//   (levels, lives, generator period) predicts the outcome. A second instance
//   with two levels and one-second periods exercises the win path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_sequencer;

  logic        Clk100M = 1'b0;
  logic        reset, tick1Hz, start, start2, userUp, userDown;
  logic [7:0]  magicCount;

  logic [3:0]  phase, phase2;
  logic [7:0]  secsLeft, secsLeft2;
  logic        startGen, stopGen, startGen2, stopGen2;
  logic [7:0]  userCount, userCount2;
  logic [3:0]  curLevel, curLevel2;
  logic [3:0]  livesLeft, livesLeft2;
  logic [31:0] symGenMax, symGenMax2;
  logic        win, gameOver, win2, gameOver2;

  int checks = 0;
  int failures = 0;

  // Reference model state (campaign level view).
  int    mLevel, mLives, mCount;
  longint mSym;
  bit    mWin, mOver;

  // Observations collected while driving a round.
  logic [3:0] curPh;
  int         obsTicks[4];
  logic [7:0] obsFirst[4];
  logic [3:0] obsPh[4];
  int         obsStarts, obsStops, obsZeros, obsSecsBad;
  logic [3:0] obsJudgePh;
  logic [7:0] obsJudgeSecs;

  int expSecs[4] = '{3, 10, 5, 3};

  always #5 Clk100M = ~Clk100M;

  game_sequencer dut (
    .Clk100M(Clk100M), .reset(reset), .tick1Hz(tick1Hz), .start(start),
    .userUp(userUp), .userDown(userDown), .magicCount(magicCount),
    .phase(phase), .secsLeft(secsLeft), .startGen(startGen), .stopGen(stopGen),
    .userCount(userCount), .curLevel(curLevel), .livesLeft(livesLeft),
    .symGenMax(symGenMax), .win(win), .gameOver(gameOver)
  );

  game_sequencer #(
    .NUM_LEVELS(2), .PRE_SECS(1), .GAME_SECS(1), .ANSWER_SECS(1), .POST_SECS(1)
  ) dut2 (
    .Clk100M(Clk100M), .reset(reset), .tick1Hz(tick1Hz), .start(start2),
    .userUp(userUp), .userDown(userDown), .magicCount(magicCount),
    .phase(phase2), .secsLeft(secsLeft2), .startGen(startGen2), .stopGen(stopGen2),
    .userCount(userCount2), .curLevel(curLevel2), .livesLeft(livesLeft2),
    .symGenMax(symGenMax2), .win(win2), .gameOver(gameOver2)
  );

  // One clock: inputs set before the call are seen at this edge, then cleared.
  task automatic stepCycle();
    @(posedge Clk100M); #1;
    tick1Hz = 0; start = 0; start2 = 0; userUp = 0; userDown = 0;
  endtask

  task automatic mRestart();
    mLevel = 0; mLives = 3; mSym = 100000000; mWin = 0; mOver = 0; mCount = 0;
  endtask

  // Round outcome from the game rules: presses applied ups-then-downs with
  // clamping to 0..255, error against magic, then level/life bookkeeping.
  task automatic modelRound(input int ups, input int downs, input int magic);
    int d;
    mCount = (ups > 255) ? 255 : ups;
    mCount = (mCount > downs) ? mCount - downs : 0;
    d = mCount - magic;
    if (d < 0) d = -d;
    if (d <= 0) begin
      if (mLevel == 9) mWin = 1;
      else begin
        mLevel++;
        mSym = (mSym - 10000000 < 20000000) ? 20000000 : mSym - 10000000;
      end
    end else if (mLives == 1) begin
      mLives = 0; mOver = 1;
    end else mLives--;
  endtask

  task automatic observe();
    if (phase == curPh) begin
      if (startGen) obsStarts++;
      if (stopGen) obsStops++;
      if (secsLeft == 8'd0) obsZeros++;
    end
  endtask

  // Drives one timed period starting at its entry cycle: an entry-cycle tick,
  // optional presses, then one tick every other cycle until the phase changes.
  task automatic runTimed(input int ups, input int downs, input int idx);
    int n;
    n = 0;
    curPh = phase; obsPh[idx] = phase; obsFirst[idx] = secsLeft;
    observe();
    tick1Hz = 1; stepCycle(); observe();
    if (phase == curPh && secsLeft !== obsFirst[idx]) obsSecsBad++;
    for (int i = 0; i < ups; i++) begin userUp = 1; stepCycle(); observe(); end
    for (int i = 0; i < downs; i++) begin userDown = 1; stepCycle(); observe(); end
    while (phase == curPh && n < 300) begin
      tick1Hz = 1; stepCycle(); n++;
      if (phase == curPh) begin
        observe();
        if (secsLeft !== obsFirst[idx] - 8'(n)) obsSecsBad++;
        stepCycle(); observe();
      end
    end
    obsTicks[idx] = n;
  endtask

  // Plays PRE..POST and the JUDGE cycle; ends on the cycle after JUDGE.
  task automatic playRound(input int ups, input int downs, input logic [7:0] magic);
    magicCount = magic;
    obsStarts = 0; obsStops = 0; obsZeros = 0; obsSecsBad = 0;
    for (int p = 0; p < 4; p++) runTimed((p == 1) ? ups : 0, (p == 1) ? downs : 0, p);
    obsJudgePh = phase; obsJudgeSecs = secsLeft;
    stepCycle();
  endtask

  task automatic test_reset();
    reset = 0; tick1Hz = 0; start = 0; start2 = 0; userUp = 0; userDown = 0; magicCount = 0;
    #1 reset = 1;
    repeat (2) @(posedge Clk100M); #1;
    checks++; if (phase !== 4'd0) begin failures++; $display("[TB] FAIL reset_phase: got %0d expected 0", phase); end
    checks++; if (secsLeft !== 8'd0) begin failures++; $display("[TB] FAIL reset_secs: got %0d expected 0", secsLeft); end
    checks++; if (livesLeft !== 4'd3) begin failures++; $display("[TB] FAIL reset_lives: got %0d expected 3", livesLeft); end
    checks++; if (symGenMax !== 32'd100000000) begin failures++; $display("[TB] FAIL reset_sym: got %0d expected 100000000", symGenMax); end
    checks++; if ({startGen, stopGen, win, gameOver, curLevel, userCount} !== 16'd0) begin
      failures++; $display("[TB] FAIL reset_misc: got %0h expected 0", {startGen, stopGen, win, gameOver, curLevel, userCount});
    end
    @(negedge Clk100M) reset = 0;
    stepCycle();
    checks++; if (phase !== 4'd0) begin failures++; $display("[TB] FAIL idle_hold: got %0d expected 0", phase); end
    mRestart();
  endtask

  task automatic test_first_round();
    start = 1; stepCycle();
    checks++; if (phase !== 4'b0001 || secsLeft !== 8'd3) begin
      failures++; $display("[TB] FAIL start_pre: got phase %0d secs %0d expected 1/3", phase, secsLeft);
    end
    playRound(0, 0, 8'd0); modelRound(0, 0, 0);
    for (int p = 0; p < 4; p++) begin
      checks++; if (obsTicks[p] !== expSecs[p]) begin failures++; $display("[TB] FAIL period%0d_ticks: got %0d expected %0d", p, obsTicks[p], expSecs[p]); end
      checks++; if (obsFirst[p] !== 8'(expSecs[p])) begin failures++; $display("[TB] FAIL period%0d_load: got %0d expected %0d", p, obsFirst[p], expSecs[p]); end
      checks++; if (obsPh[p] !== 4'(1 << p)) begin failures++; $display("[TB] FAIL period%0d_phase: got %0d expected %0d", p, obsPh[p], 1 << p); end
    end
    checks++; if (obsStarts !== 1) begin failures++; $display("[TB] FAIL startGen_pulse: got %0d cycles expected 1", obsStarts); end
    checks++; if (obsStops !== 1) begin failures++; $display("[TB] FAIL stopGen_pulse: got %0d cycles expected 1", obsStops); end
    checks++; if (obsZeros !== 0) begin failures++; $display("[TB] FAIL secs_zero_in_period: got %0d expected 0", obsZeros); end
    checks++; if (obsSecsBad !== 0) begin failures++; $display("[TB] FAIL secs_countdown: got %0d bad expected 0", obsSecsBad); end
    checks++; if (obsJudgePh !== 4'd0 || obsJudgeSecs !== 8'd0) begin
      failures++; $display("[TB] FAIL judge_outputs: got phase %0d secs %0d expected 0/0", obsJudgePh, obsJudgeSecs);
    end
    checks++; if (curLevel !== 4'd1 || symGenMax !== 32'd90000000) begin
      failures++; $display("[TB] FAIL level_up: got level %0d sym %0d expected 1/90000000", curLevel, symGenMax);
    end
    checks++; if (phase !== 4'b0001 || livesLeft !== 4'(mLives)) begin
      failures++; $display("[TB] FAIL back_to_pre: got phase %0d lives %0d expected 1/%0d", phase, livesLeft, mLives);
    end
  endtask

  task automatic test_random_rounds();
    int ups, downs, net, mg;
    for (int r = 0; r < 6; r++) begin
      ups = int'($urandom_range(0, 12));
      downs = int'($urandom_range(0, 3));
      net = (ups > downs) ? ups - downs : 0;
      mg = net + int'($urandom_range(0, 4)) - 2;
      if (mg < 0) mg = 0;
      playRound(ups, downs, 8'(mg)); modelRound(ups, downs, mg);
      checks++; if (userCount !== 8'(mCount)) begin failures++; $display("[TB] FAIL rnd%0d_count: got %0d expected %0d", r, userCount, mCount); end
      checks++; if (curLevel !== 4'(mLevel)) begin failures++; $display("[TB] FAIL rnd%0d_level: got %0d expected %0d", r, curLevel, mLevel); end
      checks++; if (livesLeft !== 4'(mLives)) begin failures++; $display("[TB] FAIL rnd%0d_lives: got %0d expected %0d", r, livesLeft, mLives); end
      checks++; if (symGenMax !== 32'(mSym)) begin failures++; $display("[TB] FAIL rnd%0d_sym: got %0d expected %0d", r, symGenMax, mSym); end
      checks++; if (gameOver !== mOver) begin failures++; $display("[TB] FAIL rnd%0d_over: got %0d expected %0d", r, gameOver, mOver); end
      if (mOver) begin
        start = 1; stepCycle(); mRestart();
        checks++; if (phase !== 4'b0001 || livesLeft !== 4'd3) begin
          failures++; $display("[TB] FAIL rnd%0d_restart: got phase %0d lives %0d expected 1/3", r, phase, livesLeft);
        end
      end
    end
  endtask

  task automatic test_game_over();
    for (int r = 0; r < 4 && !mOver; r++) begin
      playRound(5, 0, 8'd7); modelRound(5, 0, 7);
      checks++; if (livesLeft !== 4'(mLives)) begin failures++; $display("[TB] FAIL over%0d_lives: got %0d expected %0d", r, livesLeft, mLives); end
      checks++; if (curLevel !== 4'(mLevel)) begin failures++; $display("[TB] FAIL over%0d_level: got %0d expected %0d", r, curLevel, mLevel); end
    end
    checks++; if (gameOver !== 1'b1 || livesLeft !== 4'd0 || phase !== 4'd0) begin
      failures++; $display("[TB] FAIL game_over: got over %0d lives %0d phase %0d expected 1/0/0", gameOver, livesLeft, phase);
    end
    start = 1; stepCycle(); mRestart();
    checks++; if (phase !== 4'b0001 || curLevel !== 4'd0 || livesLeft !== 4'd3 || gameOver !== 1'b0) begin
      failures++; $display("[TB] FAIL over_restart: got phase %0d level %0d lives %0d over %0d expected 1/0/3/0", phase, curLevel, livesLeft, gameOver);
    end
  endtask

  task automatic test_floor();
    for (int r = 0; r < 10; r++) begin
      playRound(0, 0, 8'd0); modelRound(0, 0, 0);
      checks++; if (symGenMax !== 32'(mSym) || curLevel !== 4'(mLevel)) begin
        failures++; $display("[TB] FAIL floor%0d: got sym %0d level %0d expected %0d/%0d", r, symGenMax, curLevel, mSym, mLevel);
      end
      if (r == 8) begin
        checks++; if (symGenMax !== 32'd20000000) begin failures++; $display("[TB] FAIL sym_floor: got %0d expected 20000000", symGenMax); end
      end
    end
    checks++; if (win !== mWin || phase !== 4'd0 || curLevel !== 4'd9) begin
      failures++; $display("[TB] FAIL win_state: got win %0d phase %0d level %0d expected %0d/0/9", win, phase, curLevel, mWin);
    end
    start = 1; stepCycle(); mRestart();
    checks++; if (win !== 1'b0 || phase !== 4'b0001 || curLevel !== 4'd0 || symGenMax !== 32'd100000000) begin
      failures++; $display("[TB] FAIL win_restart: got win %0d phase %0d level %0d sym %0d", win, phase, curLevel, symGenMax);
    end
  endtask

  task automatic test_saturation();
    runTimed(0, 0, 0);
    checks++; if (phase !== 4'b0010 || startGen !== 1'b1) begin
      failures++; $display("[TB] FAIL game_entry: got phase %0d startGen %0d expected 2/1", phase, startGen);
    end
    for (int i = 0; i < 256; i++) begin userUp = 1; stepCycle(); end
    checks++; if (userCount !== 8'd255) begin failures++; $display("[TB] FAIL sat_high: got %0d expected 255", userCount); end
    userUp = 1; userDown = 1; stepCycle();
    checks++; if (userCount !== 8'd255) begin failures++; $display("[TB] FAIL both_hold: got %0d expected 255", userCount); end
    for (int i = 0; i < 300; i++) begin userDown = 1; stepCycle(); end
    checks++; if (userCount !== 8'd0) begin failures++; $display("[TB] FAIL sat_low: got %0d expected 0", userCount); end
    for (int i = 0; i < 4; i++) begin userUp = 1; stepCycle(); end
    start = 1; stepCycle();
    checks++; if (phase !== 4'b0010 || secsLeft !== 8'd10 || userCount !== 8'd4) begin
      failures++; $display("[TB] FAIL start_in_game: got phase %0d secs %0d count %0d expected 2/10/4", phase, secsLeft, userCount);
    end
  endtask

  task automatic test_reset_mid_game();
    #2 reset = 1;
    #1;
    checks++; if (phase !== 4'd0 || secsLeft !== 8'd0 || userCount !== 8'd0) begin
      failures++; $display("[TB] FAIL midreset_period: got phase %0d secs %0d count %0d expected 0/0/0", phase, secsLeft, userCount);
    end
    checks++; if (livesLeft !== 4'd3 || symGenMax !== 32'd100000000 || curLevel !== 4'd0 || {startGen, stopGen, win, gameOver} !== 4'd0) begin
      failures++; $display("[TB] FAIL midreset_state: got lives %0d sym %0d level %0d", livesLeft, symGenMax, curLevel);
    end
    @(negedge Clk100M) reset = 0;
    stepCycle();
    checks++; if (phase !== 4'd0) begin failures++; $display("[TB] FAIL midreset_idle: got %0d expected 0", phase); end
  endtask

  task automatic test_two_levels();
    int pulses, g;
    pulses = 0; g = 0;
    magicCount = 8'd0;
    start2 = 1; stepCycle();
    while (!win2 && g < 400) begin
      if (startGen2) pulses++;
      tick1Hz = (g % 2 == 1);
      stepCycle(); g++;
    end
    checks++; if (win2 !== 1'b1 || gameOver2 !== 1'b0) begin failures++; $display("[TB] FAIL two_level_win: got win %0d over %0d expected 1/0", win2, gameOver2); end
    checks++; if (pulses !== 2) begin failures++; $display("[TB] FAIL two_level_rounds: got %0d expected 2", pulses); end
    checks++; if (curLevel2 !== 4'd1 || symGenMax2 !== 32'd90000000 || livesLeft2 !== 4'd3) begin
      failures++; $display("[TB] FAIL two_level_state: got level %0d sym %0d lives %0d expected 1/90000000/3", curLevel2, symGenMax2, livesLeft2);
    end
    checks++; if (phase !== 4'd0 || curLevel !== 4'd0) begin failures++; $display("[TB] FAIL main_stays_idle: got phase %0d level %0d expected 0/0", phase, curLevel); end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_random_rounds();
    test_game_over();
    test_floor();
    test_saturation();
    test_reset_mid_game();
    test_two_levels();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
